// File: rtl/titan4_pkg.sv
// Shared definitions for the Titan-4 execute stage: opcodes, flag bit
// positions, sequencer states and instruction field helpers.
package titan4_pkg;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_AND = 4'h3;
  localparam logic [3:0] OP_ORR = 4'h4;
  localparam logic [3:0] OP_NOR = 4'h5;
  localparam logic [3:0] OP_XOR = 4'h6;
  localparam logic [3:0] OP_RSH = 4'h7;
  localparam logic [3:0] OP_LSH = 4'h8;
  localparam logic [3:0] OP_LDI = 4'h9;
  localparam logic [3:0] OP_ADI = 4'hA;
  localparam logic [3:0] OP_CMP = 4'hD;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam int F_Z  = 0;
  localparam int F_C  = 1;
  localparam int F_N  = 2;
  localparam int F_V  = 3;
  localparam int F_EQ = 4;
  localparam int F_NE = 5;
  localparam int F_GT = 6;
  localparam int F_LT = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2,
    HALT = 2'd3
  } state_t;

  function automatic logic [3:0] f_op(input logic [15:0] w);
    return w[15:12];
  endfunction

  function automatic logic [3:0] f_rd(input logic [15:0] w);
    return w[11:8];
  endfunction

  function automatic logic [3:0] f_rb(input logic [15:0] w);
    return w[7:4];
  endfunction

  function automatic logic [3:0] f_imm(input logic [15:0] w);
    return w[3:0];
  endfunction

  // Unassigned encodings retire like NOP but are reported.
  function automatic logic f_is_illegal(input logic [3:0] op);
    case (op)
      4'hB, 4'hC, 4'hE: return 1'b1;
      default:          return 1'b0;
    endcase
  endfunction

  // ADD..ADI produce a register result; CMP only touches flags.
  function automatic logic f_writes(input logic [3:0] op);
    return (op >= OP_ADD) && (op <= OP_ADI);
  endfunction

endpackage

// File: rtl/titan4_regfile.sv
// 16 x 4-bit architectural register file. r0 always reads zero and
// ignores writes; two operand read ports plus a debug read port.
module titan4_regfile
  import titan4_pkg::*;
#(
  parameter int NREGS = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       we,
  input  logic [3:0] waddr,
  input  logic [3:0] wdata,
  input  logic [3:0] raddr_a,
  output logic [3:0] rdata_a,
  input  logic [3:0] raddr_b,
  output logic [3:0] rdata_b,
  input  logic [3:0] dbg_addr,
  output logic [3:0] dbg_data
);

  logic [3:0] mem_r [NREGS];

  // Register storage: cleared on reset, single write port, r0 never written.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        mem_r[i] <= 4'd0;
      end
    end else if (we && (waddr != 4'd0)) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata_a  = (raddr_a  == 4'd0) ? 4'd0 : mem_r[raddr_a];
  assign rdata_b  = (raddr_b  == 4'd0) ? 4'd0 : mem_r[raddr_b];
  assign dbg_data = (dbg_addr == 4'd0) ? 4'd0 : mem_r[dbg_addr];

endmodule

// File: rtl/alu_sequencer.sv
// Titan-4 execute-stage controller: accepts one instruction, drives the
// external ALU for one cycle, then writes back the result and flags.
module alu_sequencer
  import titan4_pkg::*;
#(
  parameter int NREGS = 16,
  parameter int IW    = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          instr_valid,
  output logic          instr_ready,
  input  logic [IW-1:0] instr,
  output logic [3:0]    alu_op,
  output logic [3:0]    alu_a,
  output logic [3:0]    alu_b,
  input  logic [3:0]    alu_o,
  output logic [7:0]    flags,
  output logic          done,
  output logic          illegal,
  output logic          halted,
  input  logic [3:0]    dbg_addr,
  output logic [3:0]    dbg_data
);

  state_t        state_r, state_nxt_s;
  logic [IW-1:0] instr_r;
  logic [3:0]    result_r;
  logic [7:0]    flags_r, flags_pend_r, flags_nxt_s;
  logic          done_r, illegal_r, halted_r;
  logic [3:0]    op_s, rd_s, rda_s, rdb_s, opb_s;
  logic [4:0]    a5_s, b5_s, sum5_s;
  logic          we_s;

  assign op_s  = f_op(instr_r);
  assign rd_s  = f_rd(instr_r);
  assign opb_s = ((op_s == OP_LDI) || (op_s == OP_ADI)) ? f_imm(instr_r) : rdb_s;
  assign we_s  = (state_r == WB) && f_writes(op_s);

  titan4_regfile #(.NREGS(NREGS)) u_regfile (
    .clk      (clk),
    .rst      (rst),
    .we       (we_s),
    .waddr    (rd_s),
    .wdata    (result_r),
    .raddr_a  (rd_s),
    .rdata_a  (rda_s),
    .raddr_b  (f_rb(instr_r)),
    .rdata_b  (rdb_s),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  // Next-state logic for the IDLE -> EXEC -> WB -> IDLE/HALT sequence.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE:    state_nxt_s = instr_valid ? EXEC : IDLE;
      EXEC:    state_nxt_s = WB;
      WB:      state_nxt_s = (op_s == OP_HLT) ? HALT : IDLE;
      HALT:    state_nxt_s = HALT;
      default: state_nxt_s = IDLE;
    endcase
  end

  // ALU port is driven only while executing; zero otherwise.
  always_comb begin
    alu_op = 4'd0;
    alu_a  = 4'd0;
    alu_b  = 4'd0;
    if (state_r == EXEC) begin
      alu_op = op_s;
      alu_a  = rda_s;
      alu_b  = opb_s;
    end else begin
      alu_op = 4'd0;
      alu_a  = 4'd0;
      alu_b  = 4'd0;
    end
  end

  assign a5_s   = {1'b0, rda_s};
  assign b5_s   = {1'b0, opb_s};
  assign sum5_s = a5_s + b5_s;

  // Flag update for the executing opcode; untouched bits keep their value.
  always_comb begin
    flags_nxt_s = flags_r;
    case (op_s)
      OP_ADD, OP_ADI: begin
        flags_nxt_s[F_Z] = (alu_o == 4'd0);
        flags_nxt_s[F_N] = alu_o[3];
        flags_nxt_s[F_C] = sum5_s[4];
        flags_nxt_s[F_V] = (rda_s[3] == opb_s[3]) && (alu_o[3] != rda_s[3]);
      end
      OP_SUB: begin
        flags_nxt_s[F_Z] = (alu_o == 4'd0);
        flags_nxt_s[F_N] = alu_o[3];
        flags_nxt_s[F_C] = (a5_s >= b5_s);
        flags_nxt_s[F_V] = (rda_s[3] != opb_s[3]) && (alu_o[3] != rda_s[3]);
      end
      OP_AND, OP_ORR, OP_NOR, OP_XOR, OP_LDI: begin
        flags_nxt_s[F_Z] = (alu_o == 4'd0);
        flags_nxt_s[F_N] = alu_o[3];
        flags_nxt_s[F_C] = 1'b0;
        flags_nxt_s[F_V] = 1'b0;
      end
      OP_RSH, OP_LSH: begin
        flags_nxt_s[F_Z] = (alu_o == 4'd0);
        flags_nxt_s[F_N] = alu_o[3];
        flags_nxt_s[F_C] = (op_s == OP_RSH) ? rda_s[0] : rda_s[3];
        flags_nxt_s[F_V] = 1'b0;
      end
      OP_CMP: begin
        flags_nxt_s[F_EQ] = (rda_s == opb_s);
        flags_nxt_s[F_NE] = (rda_s != opb_s);
        flags_nxt_s[F_GT] = (rda_s >  opb_s);
        flags_nxt_s[F_LT] = (rda_s <  opb_s);
      end
      default: flags_nxt_s = flags_r;
    endcase
  end

  // State, latched instruction, pending result/flags and status pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      instr_r      <= {IW{1'b0}};
      result_r     <= 4'd0;
      flags_pend_r <= 8'd0;
      flags_r      <= 8'd0;
      done_r       <= 1'b0;
      illegal_r    <= 1'b0;
      halted_r     <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      done_r    <= (state_r == EXEC);
      illegal_r <= (state_r == EXEC) && f_is_illegal(op_s);
      if ((state_r == IDLE) && instr_valid) begin
        instr_r <= instr;
      end
      if (state_r == EXEC) begin
        result_r     <= alu_o;
        flags_pend_r <= flags_nxt_s;
      end
      if (state_r == WB) begin
        flags_r <= flags_pend_r;
      end
      if ((state_r == EXEC) && (op_s == OP_HLT)) begin
        halted_r <= 1'b1;
      end
    end
  end

  assign instr_ready = (state_r == IDLE) && !rst;
  assign flags       = flags_r;
  assign done        = done_r;
  assign illegal     = illegal_r;
  assign halted      = halted_r;

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer with a behavioural ALU model.
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic [3:0]  alu_op, alu_a, alu_b, alu_o;
  logic [7:0]  flags;
  logic        done, illegal, halted;
  logic [3:0]  dbg_addr, dbg_data;
  logic [3:0]  stim_addr, mon_addr;
  logic        mon_busy;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    int         acc;
    logic [7:0] fl;
    logic [3:0] r;
    logic [3:0] v;
    logic       ill;
    logic       hl;
  } exp_t;

  exp_t sb_q[$];

  alu_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .alu_op      (alu_op),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_o       (alu_o),
    .flags       (flags),
    .done        (done),
    .illegal     (illegal),
    .halted      (halted),
    .dbg_addr    (dbg_addr),
    .dbg_data    (dbg_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  assign dbg_addr = mon_busy ? mon_addr : stim_addr;

  // Behavioural combinational ALU
  always_comb begin
    case (alu_op)
      4'h1, 4'hA: alu_o = alu_a + alu_b;
      4'h2, 4'hD: alu_o = alu_a - alu_b;
      4'h3:       alu_o = alu_a & alu_b;
      4'h4:       alu_o = alu_a | alu_b;
      4'h5:       alu_o = ~(alu_a | alu_b);
      4'h6:       alu_o = alu_a ^ alu_b;
      4'h7:       alu_o = alu_a >> 1;
      4'h8:       alu_o = alu_a << 1;
      4'h9:       alu_o = alu_b;
      default:    alu_o = 4'h0;
    endcase
  end

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Monitor: on each done, pop the oldest expectation and compare
  initial begin
    exp_t e;
    mon_busy = 1'b0;
    mon_addr = 4'd0;
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_done", 16'd1, 16'd0);
        end else begin
          e = sb_q.pop_front();
          chk("done_latency", 16'(cyc - e.acc), 16'd2);
          chk("illegal", 16'(illegal), 16'(e.ill));
          chk("halted", 16'(halted), 16'(e.hl));
          mon_addr = e.r;
          mon_busy = 1'b1;
          @(posedge clk);
          #1;
          chk("flags", 16'(flags), 16'(e.fl));
          chk("reg", 16'(dbg_data), 16'(e.v));
          mon_busy = 1'b0;
        end
      end else if (illegal === 1'b1) begin
        chk("illegal_without_done", 16'd1, 16'd0);
      end
    end
  end

  task automatic issue(input logic [15:0] w, input logic [7:0] ef, input logic [3:0] r,
                       input logic [3:0] v, input logic ill, input logic hl,
                       input bit b2b, input bit chk_gap);
    int   n = 0;
    exp_t e;
    instr       = w;
    instr_valid = 1'b1;
    while (!instr_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!instr_ready) begin
      chk("accept_timeout", 16'd0, 16'd1);
    end else begin
      if (chk_gap) chk("b2b_gap", 16'(n), 16'd1);
      e.acc = cyc; e.fl = ef; e.r = r; e.v = v; e.ill = ill; e.hl = hl;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      if (!b2b) begin
        instr_valid = 1'b0;
      end else begin
        @(negedge clk);
        chk("b2b_ready_exec", 16'(instr_ready), 16'd0);
        @(negedge clk);
        chk("b2b_ready_wb", 16'(instr_ready), 16'd0);
      end
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((sb_q.size() != 0 || mon_busy) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 16'(sb_q.size()), 16'd0);
  endtask

  task automatic check_reset_zero();
    chk("rst_ready", 16'(instr_ready), 16'd0);
    chk("rst_alu", {4'd0, alu_op, alu_a, alu_b}, 16'd0);
    chk("rst_flags", 16'(flags), 16'd0);
    chk("rst_pulses", {13'd0, done, illegal, halted}, 16'd0);
    for (int i = 0; i < 16; i++) begin
      stim_addr = 4'(i);
      #1;
      chk("rst_dbg", 16'(dbg_data), 16'd0);
    end
  endtask

  initial begin
    rst         = 1'b1;
    instr_valid = 1'b0;
    instr       = 16'h0000;
    stim_addr   = 4'd0;
    repeat (2) @(negedge clk);
    check_reset_zero();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", 16'(instr_ready), 16'd1);

    //     instr     flags  reg  val  ill   hlt   b2b  gap
    issue(16'h9105, 8'h00, 4'd1, 4'h5, 1'b0, 1'b0, 1'b0, 1'b0); // LDI r1,5
    issue(16'h9203, 8'h00, 4'd2, 4'h3, 1'b0, 1'b0, 1'b0, 1'b0); // LDI r2,3
    issue(16'h1120, 8'h0C, 4'd1, 4'h8, 1'b0, 1'b0, 1'b0, 1'b0); // ADD r1,r2
    issue(16'h9304, 8'h00, 4'd3, 4'h4, 1'b0, 1'b0, 1'b0, 1'b0); // LDI r3,4
    issue(16'h9109, 8'h04, 4'd1, 4'h9, 1'b0, 1'b0, 1'b0, 1'b0); // LDI r1,9
    issue(16'h9209, 8'h04, 4'd2, 4'h9, 1'b0, 1'b0, 1'b0, 1'b0); // LDI r2,9
    issue(16'h2120, 8'h03, 4'd1, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0); // SUB r1,r2
    issue(16'hD130, 8'hA3, 4'd1, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0); // CMP r1,r3
    issue(16'h9409, 8'hA4, 4'd4, 4'h9, 1'b0, 1'b0, 1'b0, 1'b0); // LDI r4,9
    issue(16'h7400, 8'hA2, 4'd4, 4'h4, 1'b0, 1'b0, 1'b0, 1'b0); // RSH r4
    issue(16'h8400, 8'hA4, 4'd4, 4'h8, 1'b0, 1'b0, 1'b0, 1'b0); // LSH r4
    issue(16'h9007, 8'hA0, 4'd0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0); // LDI r0,7
    issue(16'hC123, 8'hA0, 4'd1, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0); // illegal 1100
    drain();

    // Back-to-back with instr_valid held high
    issue(16'hA201, 8'hA4, 4'd2, 4'hA, 1'b0, 1'b0, 1'b1, 1'b0); // ADI r2,1
    issue(16'h6220, 8'hA1, 4'd2, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1); // XOR r2,r2
    issue(16'h4240, 8'hA4, 4'd2, 4'h8, 1'b0, 1'b0, 1'b1, 1'b1); // ORR r2,r4
    issue(16'h5230, 8'hA0, 4'd2, 4'h3, 1'b0, 1'b0, 1'b1, 1'b1); // NOR r2,r3
    issue(16'h3230, 8'hA1, 4'd2, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1); // AND r2,r3
    issue(16'hD430, 8'h61, 4'd4, 4'h8, 1'b0, 1'b0, 1'b1, 1'b1); // CMP r4,r3
    instr_valid = 1'b0;
    drain();

    // Reset during EXEC of ADD r4,r3: no writeback, everything cleared
    @(negedge clk);
    instr       = 16'h1430;
    instr_valid = 1'b1;
    chk("ready_before_abort", 16'(instr_ready), 16'd1);
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    @(negedge clk);
    chk("exec_alu", {4'd0, alu_op, alu_a, alu_b}, 16'h0184);
    rst = 1'b1;
    #1;
    check_reset_zero();
    @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("no_done_after_abort", 16'(done), 16'd0);
    end
    chk("ready_idle_after_abort", 16'(instr_ready), 16'd1);
    stim_addr = 4'd4;
    #1;
    chk("r4_not_written", 16'(dbg_data), 16'd0);

    issue(16'h9506, 8'h00, 4'd5, 4'h6, 1'b0, 1'b0, 1'b0, 1'b0); // LDI r5,6
    issue(16'hF000, 8'h00, 4'd5, 4'h6, 1'b0, 1'b1, 1'b0, 1'b0); // HLT
    drain();

    // Offer ADD while halted: never accepted
    instr       = 16'h1120;
    instr_valid = 1'b1;
    repeat (8) begin
      @(negedge clk);
      chk("ready_halted", 16'(instr_ready), 16'd0);
    end
    chk("halted_held", 16'(halted), 16'd1);
    instr_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("queue_empty", 16'(sb_q.size()), 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Execute-stage controller for the Titan-4 4-bit CPU: the driving side of the ALU port. It accepts one 16-bit instruction through a valid/ready handshake, reads operands from a 16×4-bit register file, presents opcode and operands to the combinational ALU, and captures the ALU result. It then writes the result back and updates the 8-bit flag register, which it computes itself. It sits between instruction fetch and the ALU, and owns architectural register and flag state.

## Interface
- NREGS, 16, number of 4-bit registers; r0 reads as zero.
- IW, 16, instruction width; fields are op[15:12], rd[11:8], rb[7:4], imm[3:0].

- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- instr_valid  in  1  instruction offered.
- instr_ready  out  1  sequencer can accept; high only in IDLE.
- instr  in  IW  instruction word.
- alu_op  out  4  opcode driven to ALU.
- alu_a  out  4  operand A, from R[rd].
- alu_b  out  4  operand B, from R[rb], or imm for LDI/ADI.
- alu_o  in  4  ALU result.
- flags  out  8  flag register: [0]Z [1]C [2]N [3]V [4]EQ [5]NE [6]GT [7]LT.
- done  out  1  one-cycle pulse when an instruction retires.
- illegal  out  1  one-cycle pulse, coincident with done, for opcodes 1011/1100/1110.
- halted  out  1  high after HLT, until reset.
- dbg_addr  in  4  debug register-file read address.
- dbg_data  out  4  combinational R[dbg_addr].

## Operation
- Opcodes: 0000 NOP, 0001 ADD, 0010 SUB, 0011 AND, 0100 ORR, 0101 NOR, 0110 XOR, 0111 RSH, 1000 LSH, 1001 LDI, 1010 ADI, 1101 CMP, 1111 HLT. 1011, 1100 and 1110 execute as NOP and pulse illegal.
- FSM: IDLE -> EXEC -> WB -> IDLE. HLT goes IDLE -> EXEC -> WB -> HALT. HALT is absorbing until rst.
- IDLE: instr_ready=1. On valid&&ready, latch instr and go to EXEC.
- EXEC:
  - drive alu_op/alu_a/alu_b from the latched fields;
  - register alu_o into the result register;
  - compute next flags from 5-bit extended a, b.
- WB:
  - write the result to R[rd] for ALU opcodes except CMP; writes to r0 are discarded;
  - commit flags;
  - pulse done.
- Outside EXEC, alu_op/alu_a/alu_b = 0.
- Flag rules (unlisted flags unchanged):
  - ADD/ADI: Z,N from result; C = bit 4 of a+b; V = (a3==b3)&&(o3!=a3).
  - SUB: C = (a>=b), meaning no borrow; V = (a3!=b3)&&(o3!=a3); Z,N from result.
  - AND/ORR/NOR/XOR/LDI: Z,N from result; C=0, V=0.
  - RSH: C = a[0]. LSH: C = a[3]. Both also update Z,N; V=0.
  - CMP: unsigned compare of R[rd] and R[rb]. Sets EQ, NE, GT, LT; exactly one of GT/LT/EQ is set. Z,C,N,V unchanged. No write.
  - NOP/HLT/illegal: flags unchanged.
- Reset while in any state: FSM goes to IDLE. All registers, flags, done, illegal and halted clear to 0. Any in-flight instruction is dropped without writeback.

## Timing
- Reset values: instr_ready=0 while rst is high, then 1 in IDLE; all other outputs 0; dbg_data = 0 for every address.
- Acceptance at edge T. EXEC occupies cycle T..T+1. WB occupies T+1..T+2, with done high during that cycle. Register write and flags are visible after edge T+2. instr_ready rises again in cycle T+2.
- Throughput: one instruction per 3 cycles.
- instr is sampled only at acceptance. Changes to instr while not ready are ignored.
- Read-after-write: the next instruction reads the committed value, with no forwarding needed.
- dbg_data reflects a write one cycle after its WB edge.
- halted rises with the done of HLT. instr_ready stays 0 from then on.

## Structure
- Package titan4_pkg holds:
  - opcode localparams matching the list above;
  - flag bit indices;
  - FSM state enum (IDLE, EXEC, WB, HALT);
  - instruction field slice helpers.
- Sub-module titan4_regfile:
  - NREGS×4-bit storage with asynchronous reset;
  - one write port;
  - two combinational read ports plus the debug read port;
  - r0 hardwired to zero.

## Test plan
- Reset, then LDI r1,5 and LDI r2,3, then ADD r1,r2 -> R1=8, flags N=1, V=1, C=0, Z=0; done exactly 2 cycles after each acceptance.
- R1=9, R2=9: SUB r1,r2 -> R1=0, Z=1, C=1. Then CMP r1,r3 with R3=4 -> LT=1, NE=1, EQ=0, GT=0, Z still 1.
- LDI r4,0b1001, then RSH r4 -> R4=0b0100, C=1. Then LSH r4 -> R4=0b1000, C=0, N=1.
- LDI r0,7 -> R0 reads 0. Opcode 1100 -> illegal pulses with done; flags and registers unchanged.
- Hold instr_valid high with back-to-back instructions -> instr_ready pattern 1,0,0 repeats; exactly one accept per 3 cycles.
- HLT, then offer ADD -> halted=1, instr_ready stays 0. Assert rst during an EXEC cycle -> no writeback, all outputs 0, IDLE after release.
